// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the execute-stage multiply/divide unit:
//     - md_op_e    : decoded MD operation codes (codes 9..15 behave as NONE)
//     - MULT_CYC_DEF / DIV_CYC_DEF : default busy latencies
//     - is_md_start(op) : op launches a multi-cycle mult/div
//     - is_md_div(op)   : op is one of the divide forms
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  // True for the two divide forms (selects the longer latency).
  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// ---------------------------------------------------------------------------
// md_calc
//   Purely combinational arithmetic core for the MD unit.
//   Ports:
//     op       in  4   decoded MD operation (md_pkg encoding)
//     a        in  32  rs operand (dividend / multiplicand)
//     b        in  32  rt operand (divisor / multiplier)
//     res_hi   out 32  upper product word, or remainder
//     res_lo   out 32  lower product word, or quotient
//     div_zero out 1   divide op with b == 0 (result must not be committed)
//   For non-mult/div ops the results are zero.
// ---------------------------------------------------------------------------
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  // Multiplication: sign-extend to 64 bits so the low 64 bits of the product
  // are the exact signed result.
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] smul;
  logic        [63:0] umul;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};
  assign smul = a_sx * b_sx;
  assign umul = {32'd0, a} * {32'd0, b};

  // Division: one unsigned divider shared by both forms. The signed form
  // divides magnitudes and fixes signs afterwards, which also makes
  // 0x80000000 / -1 fall out as 0x80000000 rem 0 with no special case.
  logic        a_neg;
  logic        b_neg;
  logic        is_signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  assign is_signed_div = (op == MD_DIV);
  assign a_neg         = a[31];
  assign b_neg         = b[31];
  assign a_mag         = a_neg ? (~a + 32'd1) : a;
  assign b_mag         = b_neg ? (~b + 32'd1) : b;
  assign num           = is_signed_div ? a_mag : a;
  assign den           = is_signed_div ? b_mag : b;
  // Keep the divider well defined for b == 0; the result is discarded anyway.
  assign den_safe      = (den == 32'd0) ? 32'd1 : den;
  assign uq            = num / den_safe;
  assign ur            = num % den_safe;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign sq            = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign sr            = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = smul[63:32];
        res_lo = smul[31:0];
      end
      MD_MULTU: begin
        res_hi = umul[63:32];
        res_lo = umul[31:0];
      end
      MD_DIV: begin
        res_hi   = sr;
        res_lo   = sq;
        div_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        res_hi   = ur;
        res_lo   = uq;
        div_zero = (b == 32'd0);
      end
      default: begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Execute-stage multiply/divide unit. Owns HI/LO and models multi-cycle
//   mult/div latency with a busy down-counter. The result is computed at
//   launch and held in pending registers until the counter expires.
//   Ports:
//     clk      in  1   system clock, rising edge
//     reset_n  in  1   asynchronous active-low reset
//     md_op    in  4   decoded E-stage MD operation (md_pkg encoding)
//     start    in  1   E-stage instruction valid; qualifies md_op
//     A        in  32  forwarded rs value
//     B        in  32  forwarded rt value
//     busy     out 1   high while a mult/div is in flight
//     hi       out 32  architectural HI
//     lo       out 32  architectural LO
//     md_out   out 32  mfhi/mflo result (combinational, ignores start)
// ---------------------------------------------------------------------------
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,  // busy cycles for mult/multu, >= 1
  parameter int DIV_CYC  = DIV_CYC_DEF    // busy cycles for div/divu, >= 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_skip;   // divide by zero: run the latency, drop result

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_div_zero;
  logic [CNT_W-1:0] launch_cnt;
  logic             accept;       // unit idle and instruction valid

  md_calc u_calc (
    .op       (md_op),
    .a        (A),
    .b        (B),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_div_zero)
  );

  assign accept     = start && !busy;
  assign launch_cnt = is_md_div(md_op) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      count     <= '0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_skip <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else if (busy) begin
      // Any start while busy is ignored; only the countdown advances.
      if (count == CNT_W'(1)) begin
        if (!pend_skip) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (accept) begin
      if (is_md_start(md_op)) begin
        pend_hi   <= calc_hi;
        pend_lo   <= calc_lo;
        pend_skip <= calc_div_zero;
        count     <= launch_cnt;
        busy      <= 1'b1;
      end else if (md_op == MD_MTHI) begin
        hi <= A;
      end else if (md_op == MD_MTLO) begin
        lo <= A;
      end
    end
  end

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi;
      MD_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
//   Directed + random stimulus for md_unit. The reference model tracks HI/LO
//   and the time (edge index) at which an in-flight op completes, computing
//   results with 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  md_unit #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md_op   (md_op),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_commit;
  bit          m_busy;
  longint      m_edge = 0;
  longint      m_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh,
                                   output logic [31:0] rl, output bit commit);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = 32'd0; rl = 32'd0; commit = 1'b1;
    case (op)
      OP_MULT: begin
        p  = 64'(sa * sb);
        rh = p[63:32]; rl = p[31:0];
      end
      OP_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        rh = p[63:32]; rl = p[31:0];
      end
      OP_DIV: begin
        commit = (b != 32'd0);
        if (commit) begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      OP_DIVU: begin
        commit = (b != 32'd0);
        if (commit) begin
          rl = a / b; rh = a % b;
        end
      end
      default: commit = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
    m_commit = 1'b0; m_busy = 1'b0;
  endtask

  // One rising edge with the given inputs.
  task automatic model_edge(input logic [3:0] op, input logic st,
                            input logic [31:0] a, input logic [31:0] b);
    m_edge++;
    if (m_busy) begin
      if (m_edge == m_done) begin
        if (m_commit) begin
          m_hi = m_phi; m_lo = m_plo;
        end
        m_busy = 1'b0;
      end
    end else if (st) begin
      if (op >= OP_MULT && op <= OP_DIVU) begin
        ref_calc(op, a, b, m_phi, m_plo, m_commit);
        m_busy = 1'b1;
        m_done = m_edge + ((op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N);
      end else if (op == OP_MTHI) begin
        m_hi = a;
      end else if (op == OP_MTLO) begin
        m_lo = a;
      end
    end
  endtask

  // Called at a negedge: drive, check md_out, clock once, check state.
  task automatic step(input logic [3:0] op, input logic st,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    md_op = op; start = st; A = a; B = b;
    if (st)
      $display("txn t=%0t op=%0d a=%08h b=%08h busy=%0b hi=%08h lo=%08h",
               $time, op, a, b, busy, hi, lo);
    #1;
    exp_out = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
    check("md_out", md_out, exp_out);
    @(posedge clk);
    model_edge(op, st, a, b);
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    @(negedge clk);
  endtask

  // Idle until busy drops (bounded); n = number of busy cycles observed.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step(OP_NONE, 1'b0, 32'd0, 32'd0);
    end
  endtask

  int n;
  logic [3:0]  r_op;
  logic        r_st;
  logic [31:0] r_a, r_b;

  initial begin
    reset_n = 1'b0; md_op = OP_NONE; start = 1'b0; A = 32'd0; B = 32'd0;
    model_reset();
    @(negedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_md_out", md_out, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Signed / unsigned multiply
    step(OP_MULT, 1'b1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("mult_cycles", n, MULT_N);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    step(OP_MULTU, 1'b1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("multu_cycles", n, MULT_N);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    // Signed / unsigned divide
    step(OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, DIV_N);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    step(OP_DIVU, 1'b1, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // Divide by zero keeps HI/LO; overflow case
    step(OP_MTHI, 1'b1, 32'h11, 32'd0);
    step(OP_MTLO, 1'b1, 32'h22, 32'd0);
    check("mt_hi", hi, 32'h11);
    check("mt_lo", lo, 32'h22);
    step(OP_DIV, 1'b1, 32'd5, 32'd0);
    wait_idle(n);
    check("div0_cycles", n, DIV_N);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    step(OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);

    // Start while busy is ignored
    step(OP_MULT, 1'b1, 32'd2, 32'd3);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2)      step(OP_DIVU, 1'b1, 32'd9, 32'd3);
      else if (n == 3) step(OP_MTLO, 1'b1, 32'h55, 32'd0);
      else             step(OP_NONE, 1'b0, 32'd0, 32'd0);
    end
    check("busyign_cycles", n, MULT_N);
    check("busyign_lo", lo, 32'd6);
    check("busyign_hi", hi, 32'd0);

    // MT/MF path
    step(OP_MTHI, 1'b1, 32'hDEADBEEF, 32'd0);
    check("mthi", hi, 32'hDEADBEEF);
    md_op = OP_MFHI; start = 1'b0; #1;
    check("mfhi_out", md_out, 32'hDEADBEEF);
    md_op = OP_MFLO; #1;
    check("mflo_out", md_out, 32'd6);
    md_op = OP_MULT; #1;
    check("mf_other_out", md_out, 32'd0);
    md_op = OP_NONE;
    @(negedge clk);

    // Back-to-back launch in the first idle cycle
    step(OP_MULT, 1'b1, 32'd7, 32'd6);
    wait_idle(n);
    check("b2b_first_lo", lo, 32'd42);
    step(OP_MULT, 1'b1, 32'd100, 32'd200);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b_cycles", n, MULT_N);
    check("b2b_lo", lo, 32'd20000);
    check("b2b_hi", hi, 32'd0);

    // Asynchronous reset in the middle of a multiply
    step(OP_MTHI, 1'b1, 32'h1234, 32'd0);
    step(OP_MULT, 1'b1, 32'd3, 32'd5);
    step(OP_NONE, 1'b0, 32'd0, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    repeat (8) step(OP_NONE, 1'b0, 32'd0, 32'd0);
    check("arst_after_lo", lo, 32'd0);
    check("arst_after_hi", hi, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_st = ($urandom_range(0, 3) != 0);
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 9));
        2:       r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      step(r_op, r_st, r_a, r_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
